// File: rtl/nx_fifo_bit_packer.sv
// Serial-to-parallel packer: drains a show-ahead 1-bit FIFO into OUT_W-bit words
// behind a valid/ready port, with a flush path that emits partially filled words.
module nx_fifo_bit_packer #(
  parameter int OUT_W     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter int CNT_W     = 16,
  localparam int NB_W     = $clog2(OUT_W + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fifo_empty,
  input  logic             fifo_rdata,
  output logic             fifo_ren,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [NB_W-1:0]  out_nbits,
  output logic [CNT_W-1:0] word_cnt,
  output logic             busy
);

  localparam logic [NB_W-1:0] FULL_CNT = NB_W'(OUT_W);

  logic [OUT_W-1:0] acc_reg, acc_next, acc_pop;
  logic [NB_W-1:0]  acc_cnt_reg, acc_cnt_next, cnt_after;
  logic [OUT_W-1:0] out_data_reg, out_data_next;
  logic [NB_W-1:0]  out_nbits_reg, out_nbits_next;
  logic             out_valid_reg, out_valid_next;
  logic             flush_pend_reg, flush_pend_next;
  logic [CNT_W-1:0] word_cnt_reg, word_cnt_next;

  logic slot_free;
  logic pop;
  logic xfer;
  logic load_full;
  logic load_flush;
  logic load;

  assign slot_free = !out_valid_reg || out_ready;
  assign xfer      = out_valid_reg && out_ready;

  // No pops while a flush is pending so the flushed word is exactly what was accumulated.
  assign pop       = !rst && !fifo_empty && !flush_pend_reg && (acc_cnt_reg < FULL_CNT);
  assign cnt_after = acc_cnt_reg + NB_W'(pop);

  // Each accumulator bit owns one fill index; only that index may write it.
  generate
    for (genvar gi = 0; gi < OUT_W; gi++) begin : g_place
      localparam logic [NB_W-1:0] SLOT = MSB_FIRST ? NB_W'(OUT_W - 1 - gi) : NB_W'(gi);
      assign acc_pop[gi] = (pop && (acc_cnt_reg == SLOT)) ? fifo_rdata : acc_reg[gi];
    end
  endgenerate

  // A word that was held full behind a stalled output also completes through load_full.
  assign load_full  = (cnt_after == FULL_CNT) && slot_free;
  assign load_flush = flush_pend_reg && (acc_cnt_reg != '0) && slot_free;
  assign load       = load_full || load_flush;

  always_comb begin
    acc_next        = acc_pop;
    acc_cnt_next    = cnt_after;
    out_data_next   = out_data_reg;
    out_nbits_next  = out_nbits_reg;
    out_valid_next  = out_valid_reg;
    flush_pend_next = flush_pend_reg;
    word_cnt_next   = word_cnt_reg + CNT_W'(xfer);

    if (xfer) begin
      out_valid_next = 1'b0;
    end

    if (load) begin
      out_data_next  = acc_pop;
      out_nbits_next = cnt_after;
      out_valid_next = 1'b1;
      acc_next       = '0;
      acc_cnt_next   = '0;
    end

    // A pending flush absorbs further flush pulses until it resolves.
    if (flush_pend_reg) begin
      if ((acc_cnt_reg == '0) || load) begin
        flush_pend_next = 1'b0;
      end
    end else begin
      flush_pend_next = flush;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_reg        <= '0;
      acc_cnt_reg    <= '0;
      out_data_reg   <= '0;
      out_nbits_reg  <= '0;
      out_valid_reg  <= 1'b0;
      flush_pend_reg <= 1'b0;
      word_cnt_reg   <= '0;
    end else begin
      acc_reg        <= acc_next;
      acc_cnt_reg    <= acc_cnt_next;
      out_data_reg   <= out_data_next;
      out_nbits_reg  <= out_nbits_next;
      out_valid_reg  <= out_valid_next;
      flush_pend_reg <= flush_pend_next;
      word_cnt_reg   <= word_cnt_next;
    end
  end

  assign fifo_ren  = pop;
  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_nbits = out_nbits_reg;
  assign word_cnt  = word_cnt_reg;
  assign busy      = (acc_cnt_reg != '0) || out_valid_reg || flush_pend_reg;

endmodule
